packet_buffer_read_arbiter: RTL and testbench

Shares the single read port of the packet buffer RAM driver between NUM_REQ streaming readers, for example the UART dump reader and the Ethernet frame transmitter.
- Accepts one-word read requests and grants them round-robin, with one RAM read outstanding at a time.
- Routes each RAM response back to its owner.
- Recovers from a missing response via a watchdog.
- Sits between the readers and packet_buffer_ram_driver's readclk/raddr/outclk/out port.

---
 rtl/packet_buffer_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_packet_buffer_read_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_buffer_read_arbiter.sv
// Round-robin arbiter sharing the packet buffer RAM driver read port
// between NUM_REQ streaming readers. One RAM read is outstanding at a time.
// Each response is routed back to its owner. A watchdog aborts reads that
// never receive a response.
module packet_buffer_read_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_LEN   = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_busy,
    output logic [NUM_REQ-1:0]            rd_outclk,
    output logic [WORD_LEN-1:0]           rd_out,
    output logic [NUM_REQ-1:0]            rd_err,
    output logic [NUM_REQ-1:0]            overflow,
    output logic                          ram_readclk,
    output logic [ADDR_WIDTH-1:0]         ram_raddr,
    input  logic                          ram_outclk,
    input  logic [WORD_LEN-1:0]           ram_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [NUM_REQ-1:0]    pending;
    logic [ADDR_WIDTH-1:0] addr_q   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         owner;
    logic [CW-1:0]         cnt;

    logic [NUM_REQ-1:0]    accept;
    logic [NUM_REQ-1:0]    cand;
    logic                  grant_found;
    logic [PW-1:0]         grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [NUM_REQ-1:0]    owner_mask;
    logic [NUM_REQ-1:0]    grant_mask;
    logic                  done;
    logic [NUM_REQ-1:0]    busy_next;
    logic [NUM_REQ-1:0]    pending_next;
    int unsigned           idx;

    // Unpack the per-requester address slices
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Acceptance, round-robin search from ptr+1 with wrap, and next busy/pending
    always_comb begin
        accept      = rd_req & ~rd_busy;
        cand        = pending | accept;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && cand[idx[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PW-1:0];
            end
        end
        // A pending slot is always busy, so it cannot also be accepted this cycle
        grant_addr = pending[grant_idx] ? addr_q[grant_idx] : req_addr[grant_idx];
        owner_mask = '0;
        grant_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            owner_mask[i] = (owner == PW'(i));
            grant_mask[i] = grant_found && (grant_idx == PW'(i));
        end
        done         = (state == WAIT) && (ram_outclk || (cnt == CW'(TIMEOUT - 1)));
        busy_next    = (rd_busy & ~(done ? owner_mask : '0)) | accept;
        pending_next = cand & ~((state == IDLE) ? grant_mask : '0);
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            ptr         <= PW'(NUM_REQ - 1);
            owner       <= '0;
            cnt         <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
            end
            rd_busy     <= '0;
            rd_outclk   <= '0;
            rd_out      <= '0;
            rd_err      <= '0;
            overflow    <= '0;
            ram_readclk <= 1'b0;
            ram_raddr   <= '0;
        end else begin
            rd_outclk   <= '0;
            rd_err      <= '0;
            ram_readclk <= 1'b0;
            rd_busy     <= busy_next;
            pending     <= pending_next;
            overflow    <= overflow | (rd_req & rd_busy);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    addr_q[i] <= req_addr[i];
                end
            end
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        ram_readclk <= 1'b1;
                        ram_raddr   <= grant_addr;
                        owner       <= grant_idx;
                        ptr         <= grant_idx;
                        cnt         <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ram_outclk) begin
                        rd_outclk <= owner_mask;
                        rd_out    <= ram_out;
                        state     <= IDLE;
                    end else if (done) begin
                        rd_err <= owner_mask;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Self-checking bench for packet_buffer_read_arbiter: directed scenarios
// followed by randomized traffic checked against a transaction-level model.
module tb_packet_buffer_read_arbiter;

    localparam int NR = 2;
    localparam int AW = 12;
    localparam int WL = 8;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0]    rd_busy;
    logic [NR-1:0]    rd_outclk;
    logic [WL-1:0]    rd_out;
    logic [NR-1:0]    rd_err;
    logic [NR-1:0]    overflow;
    logic             ram_readclk;
    logic [AW-1:0]    ram_raddr;
    logic             ram_outclk;
    logic [WL-1:0]    ram_out;

    int checks = 0;
    int errors = 0;

    packet_buffer_read_arbiter #(
        .NUM_REQ(NR),
        .ADDR_WIDTH(AW),
        .WORD_LEN(WL),
        .TIMEOUT(TO)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_busy(rd_busy),
        .rd_outclk(rd_outclk),
        .rd_out(rd_out),
        .rd_err(rd_err),
        .overflow(overflow),
        .ram_readclk(ram_readclk),
        .ram_raddr(ram_raddr),
        .ram_outclk(ram_outclk),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int i, input logic [AW-1:0] a);
        rd_req[i] = 1'b1;
        rd_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [WL-1:0] data_of(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int            n;
        int            e;
        int            nrc;
        int            r;
        logic [NR-1:0] exp_oc;
        logic [NR-1:0] exp_er;
        logic [NR-1:0] bmask;
        logic [AW-1:0] a;
        bit            busy_m  [NR];
        bit            issued_m[NR];
        logic [AW-1:0] addr_m  [NR];
        int            last;
        bit            outst;
        int            own;
        int            exp_grant;
        int            resp_at;
        int            exp_kind;
        int            exp_cyc;
        logic [WL-1:0] exp_data;
        int            j;

        rst = 1'b1; rd_req = '0; rd_addr = '0; ram_outclk = 1'b0; ram_out = '0;
        tick(); tick();
        check("rst_busy", rd_busy, 0);
        check("rst_outclk", rd_outclk, 0);
        check("rst_out", rd_out, 0);
        check("rst_err", rd_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_readclk", ram_readclk, 0);
        check("rst_raddr", ram_raddr, 0);
        rst = 1'b0;
        tick();

        // 1: single read with RAM latency 2
        req(0, 12'h005);
        tick(); rd_req = '0;
        check("t1_readclk", ram_readclk, 1);
        check("t1_raddr", ram_raddr, 12'h005);
        check("t1_busy_a", rd_busy, 2'b01);
        tick();
        check("t1_readclk_low", ram_readclk, 0);
        check("t1_busy_b", rd_busy, 2'b01);
        tick();
        check("t1_busy_c", rd_busy, 2'b01);
        ram_outclk = 1'b1; ram_out = 8'hA5;
        tick(); ram_outclk = 1'b0;
        check("t1_outclk", rd_outclk, 2'b01);
        check("t1_out", rd_out, 8'hA5);
        check("t1_busy_d", rd_busy, 2'b00);
        check("t1_err", rd_err, 0);

        // 2: simultaneous requests after reset
        rst = 1'b1; tick(); rst = 1'b0;
        req(0, 12'h010); req(1, 12'h020);
        tick(); rd_req = '0;
        check("t2_readclk_a", ram_readclk, 1);
        check("t2_raddr_a", ram_raddr, 12'h010);
        check("t2_busy_a", rd_busy, 2'b11);
        ram_outclk = 1'b1; ram_out = 8'h11;
        tick(); ram_outclk = 1'b0;
        check("t2_outclk_a", rd_outclk, 2'b01);
        check("t2_out_a", rd_out, 8'h11);
        check("t2_busy_b", rd_busy, 2'b10);
        check("t2_readclk_gap", ram_readclk, 0);
        tick();
        check("t2_readclk_b", ram_readclk, 1);
        check("t2_raddr_b", ram_raddr, 12'h020);
        check("t2_outclk_gap", rd_outclk, 0);
        ram_outclk = 1'b1; ram_out = 8'h22;
        tick(); ram_outclk = 1'b0;
        check("t2_outclk_b", rd_outclk, 2'b10);
        check("t2_out_b", rd_out, 8'h22);
        check("t2_busy_c", rd_busy, 2'b00);

        // 3: both requesters re-request on every response
        req(0, 12'h100); req(1, 12'h200);
        tick(); rd_req = '0;
        for (int t = 0; t < 8; t++) begin
            e = t % 2;
            n = 0;
            while (!ram_readclk && n < 10) begin
                tick(); n++;
            end
            check("t3_grant_seen", ram_readclk, 1);
            check("t3_owner", ram_raddr[11:8], e + 1);
            ram_outclk = 1'b1; ram_out = WL'(t);
            tick(); ram_outclk = 1'b0;
            check("t3_outclk", rd_outclk, 1 << e);
            check("t3_out", rd_out, t);
            if (t < 6) req(e, AW'(((e + 1) << 8) + t));
            tick(); rd_req = '0;
        end
        check("t3_overflow", overflow, 0);
        check("t3_busy", rd_busy, 0);

        // 4: RAM never responds
        req(0, 12'h0AB);
        tick(); rd_req = '0;
        check("t4_readclk", ram_readclk, 1);
        for (int k = 1; k < TO; k++) begin
            tick();
            check("t4_no_err_early", rd_err, 0);
        end
        tick();
        check("t4_err", rd_err, 2'b01);
        check("t4_busy", rd_busy, 0);
        check("t4_no_outclk", rd_outclk, 0);
        tick();
        check("t4_err_once_a", rd_err, 0);
        tick();
        check("t4_err_once_b", rd_err, 0);
        tick();
        ram_outclk = 1'b1; ram_out = 8'hEE;
        tick(); ram_outclk = 1'b0;
        check("t4_stray_outclk", rd_outclk, 0);
        check("t4_stray_err", rd_err, 0);
        check("t4_stray_readclk", ram_readclk, 0);

        // 5: overflow on requests while busy
        nrc = 0;
        req(1, 12'h055);
        tick(); rd_req = '0; nrc += int'(ram_readclk);
        check("t5_busy", rd_busy, 2'b10);
        req(1, 12'h066);
        tick(); rd_req = '0; nrc += int'(ram_readclk);
        tick(); nrc += int'(ram_readclk);
        req(1, 12'h077);
        tick(); rd_req = '0; nrc += int'(ram_readclk);
        check("t5_overflow", overflow, 2'b10);
        ram_outclk = 1'b1; ram_out = 8'h5A;
        tick(); ram_outclk = 1'b0; nrc += int'(ram_readclk);
        check("t5_outclk", rd_outclk, 2'b10);
        check("t5_out", rd_out, 8'h5A);
        check("t5_raddr_held", ram_raddr, 12'h055);
        for (int k = 0; k < 4; k++) begin
            tick(); nrc += int'(ram_readclk);
        end
        check("t5_readclk_count", nrc, 1);
        check("t5_overflow_sticky", overflow, 2'b10);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_overflow_clr", overflow, 0);

        // 6: reset during WAIT
        req(0, 12'h077);
        tick(); rd_req = '0;
        check("t6_readclk", ram_readclk, 1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_busy", rd_busy, 0);
        check("t6_outclk", rd_outclk, 0);
        check("t6_err", rd_err, 0);
        check("t6_readclk_clr", ram_readclk, 0);
        check("t6_raddr_clr", ram_raddr, 0);
        check("t6_out_clr", rd_out, 0);
        ram_outclk = 1'b1; ram_out = 8'h99;
        tick(); ram_outclk = 1'b0;
        check("t6_late_outclk", rd_outclk, 0);
        check("t6_late_err", rd_err, 0);
        req(1, 12'h0CD);
        tick(); rd_req = '0;
        check("t6_new_readclk", ram_readclk, 1);
        check("t6_new_raddr", ram_raddr, 12'h0CD);
        ram_outclk = 1'b1; ram_out = 8'h3C;
        tick(); ram_outclk = 1'b0;
        check("t6_new_outclk", rd_outclk, 2'b10);
        check("t6_new_out", rd_out, 8'h3C);

        // Randomized traffic against a transaction-level model
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            busy_m[i] = 1'b0; issued_m[i] = 1'b0; addr_m[i] = '0;
        end
        last = NR - 1; outst = 1'b0; own = 0; exp_grant = -1;
        resp_at = -1; exp_kind = 0; exp_cyc = 0; exp_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_oc = '0; exp_er = '0;
            if (exp_kind != 0 && cyc == exp_cyc) begin
                if (exp_kind == 1) exp_oc[own] = 1'b1;
                else exp_er[own] = 1'b1;
            end
            check("rnd_outclk", rd_outclk, exp_oc);
            check("rnd_err", rd_err, exp_er);
            if (exp_kind == 1 && cyc == exp_cyc) check("rnd_data", rd_out, exp_data);
            if (exp_kind != 0 && cyc == exp_cyc) begin
                busy_m[own] = 1'b0; outst = 1'b0; exp_kind = 0;
            end
            check("rnd_readclk", ram_readclk, exp_grant >= 0);
            if (exp_grant >= 0) begin
                check("rnd_raddr", ram_raddr, addr_m[exp_grant]);
                own = exp_grant; last = own; issued_m[own] = 1'b1; outst = 1'b1;
                r = int'($urandom_range(0, 99));
                if (r < 10) begin
                    resp_at = -1; exp_kind = 2; exp_cyc = cyc + TO;
                end else begin
                    resp_at = cyc + ((r < 90) ? int'($urandom_range(0, 4))
                                              : int'($urandom_range(5, TO - 1)));
                    exp_kind = 1; exp_cyc = resp_at + 1; exp_data = data_of(addr_m[own]);
                end
            end
            for (int i = 0; i < NR; i++) bmask[i] = busy_m[i];
            check("rnd_busy", rd_busy, bmask);
            check("rnd_overflow", overflow, 0);

            ram_outclk = 1'b0; ram_out = WL'($urandom);
            if (outst && resp_at == cyc) begin
                ram_outclk = 1'b1; ram_out = data_of(addr_m[own]);
            end else if (!outst && $urandom_range(0, 19) == 0) begin
                ram_outclk = 1'b1;
            end
            rd_req = '0;
            for (int i = 0; i < NR; i++) begin
                if (!busy_m[i] && cyc < 2900 && $urandom_range(0, 3) == 0) begin
                    a = AW'($urandom);
                    req(i, a);
                    addr_m[i] = a; busy_m[i] = 1'b1; issued_m[i] = 1'b0;
                end
            end
            exp_grant = -1;
            if (!outst) begin
                for (int k = 1; k <= NR; k++) begin
                    j = (last + k) % NR;
                    if (exp_grant < 0 && busy_m[j] && !issued_m[j]) exp_grant = j;
                end
            end
            tick();
        end
        check("rnd_drain_busy", rd_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
